// File: rtl/i2c_temp_target.sv
// I2C target exposing a 16-bit temperature snapshot, a device-ID register and
// a write-loaded register pointer; SCL/SDA are synchronized and glitch-filtered.
`timescale 1ns/1ps
module i2c_temp_target #(
  parameter logic [6:0]  I2C_ADDR = 7'h4B,
  parameter int unsigned FILT_LEN = 3,
  parameter logic [7:0]  DEV_ID   = 8'hCB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] temp,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        busy,
  output logic        rd_strobe
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_PTR   = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  // Line conditioning: 2-FF synchronizer, then a level filter that only moves
  // once FILT_LEN consecutive samples agree.
  logic [1:0]          scl_sync, sda_sync;
  logic [FILT_LEN-1:0] scl_hist, sda_hist;
  logic                scl_f, sda_f, scl_d, sda_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[1]};
      if (&scl_hist)      scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)      sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  // SCL must be high on both sides of the SDA edge, so SDA moves while SCL is
  // low never decode as bus conditions.
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n, tx, tx_n, ptr, ptr_n, rx_byte, rd_data;
  logic [15:0] snap, snap_n;
  logic        rw, rw_n, ptr_set, ptr_set_n;
  logic        sda_oe_n, busy_n, rd_strobe_n;

  assign rx_byte = {shreg[6:0], sda_f};

  always_comb begin
    unique case (ptr)
      8'h00:   rd_data = snap[15:8];
      8'h01:   rd_data = snap[7:0];
      8'h0B:   rd_data = DEV_ID;
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    tx_n        = tx;
    ptr_n       = ptr;
    snap_n      = snap;
    rw_n        = rw;
    ptr_set_n   = ptr_set;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    rd_strobe_n = 1'b0;

    if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
      ptr_set_n = 1'b0;
    end else begin
      unique case (state)
        ADDR: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            if (rx_byte[7:1] == I2C_ADDR) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              rw_n    = rx_byte[0];
              if (rx_byte[0]) begin
                snap_n      = temp;
                rd_strobe_n = 1'b1;
              end
            end else begin
              state_n = IGNORE;
            end
          end
        end

        // sda_oe doubles as the ACK-slot phase: low before the slot, high in it.
        ADDR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else if (rw) begin
            tx_n      = rd_data;
            sda_oe_n  = ~rd_data[7];
            ptr_n     = ptr + 8'd1;
            bit_cnt_n = 4'd0;
            state_n   = RD_BYTE;
          end else begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = WR_PTR;
          end
        end

        WR_PTR: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            state_n   = WR_ACK;
            if (!ptr_set) begin
              ptr_n     = rx_byte;
              ptr_set_n = 1'b1;
            end
          end
        end

        WR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else begin
            sda_oe_n = 1'b0;
            state_n  = WR_PTR;
          end
        end

        RD_BYTE: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 4'd0;
              state_n   = RD_ACK;
            end else if (bit_cnt != 4'd0) begin
              sda_oe_n = ~tx[6];
              tx_n     = {tx[6:0], 1'b0};
            end
          end
        end

        // bit_cnt == 1 records that the master acknowledged the last byte.
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_n = IGNORE;
            end else begin
              bit_cnt_n = 4'd1;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            tx_n      = rd_data;
            sda_oe_n  = ~rd_data[7];
            ptr_n     = ptr + 8'd1;
            bit_cnt_n = 4'd0;
            state_n   = RD_BYTE;
          end
        end

        IGNORE:  sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      tx        <= 8'h00;
      ptr       <= 8'h00;
      snap      <= 16'h0000;
      rw        <= 1'b0;
      ptr_set   <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rd_strobe <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      tx        <= tx_n;
      ptr       <= ptr_n;
      snap      <= snap_n;
      rw        <= rw_n;
      ptr_set   <= ptr_set_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      rd_strobe <= rd_strobe_n;
    end
  end

endmodule
